fi_fault_monitor: RTL
=====================

Name: fi_fault_monitor

Overview:
Golden-model checker that sits beside the fault-injection target and observes the same inputs (a, enable) and the target's registered outputs (o1, o2, o3). It runs a cycle-accurate shadow of the target's three-flop datapath and compares it with the outputs every cycle. When armed, it detects and counts divergences caused by VPI-injected faults, captures the first fault's timestamp and bit vector, and raises an alarm at a threshold. It is the observing end of the injection flow.

Parameters:
CNT_W, 16, width of mismatch counter err_count
TS_W, 32, width of free-running cycle timestamp and first_ts
THRESH, 4, mismatch-cycle count at which alarm asserts (legal 1..2^CNT_W-1)

Ports:
clk  input  1  clock
reset  input  1  reset, asynchronous, active-high
arm  input  1  level/pulse; starts monitoring from IDLE
clear  input  1  pulse; returns to IDLE and clears all capture state
a  input  1  same data input driven to target
enable  input  1  same enable driven to target
o1  input  1  target output o1
o2  input  1  target output o2
o3  input  1  target output o3
fault  output  1  sticky; 1 once any mismatch seen while armed
alarm  output  1  sticky; 1 once err_count >= THRESH
err_count  output  CNT_W  number of mismatching cycles, saturating
first_ts  output  TS_W  timestamp of first mismatching cycle
first_vec  output  3  {o3^s3, o2^s2, o1^s1} at first mismatch
state  output  2  0=IDLE 1=ARMED 2=FAULT 3=ALARM

Behaviour:
- Reset: s1=s2=s3=0, ts=0, state=IDLE, fault=0, alarm=0, err_count=0, first_ts=0, first_vec=0.
- Shadow model runs every cycle out of reset, independent of state: s1<=enable?a:s1; s2<=s1; s3<=!s1. Never cleared by clear; it tracks the target from reset.
- ts increments every clock after reset; saturates at all-ones.
- mis = {o3,o2,o1} ^ {s3,s2,s1}, combinational; any_mis = |mis. Compared only in ARMED/FAULT/ALARM.
- Latency: a mismatch present in cycle N appears on state/fault/err_count/first_* after the clock edge ending cycle N (1 cycle). first_ts = ts value during cycle N.
- FSM:
  IDLE: arm -> ARMED. mis ignored.
  ARMED: any_mis -> err_count=1, first_ts=ts, first_vec=mis, fault=1; next = ALARM if THRESH==1 else FAULT.
  FAULT: any_mis -> err_count+1; if err_count+1 >= THRESH -> ALARM, alarm=1.
  ALARM: any_mis -> err_count+1 saturating at all-ones; stays in ALARM.
- arm outside IDLE is ignored; arm held high does nothing extra.
- clear has priority over arm and mismatch in the same cycle: next state IDLE, fault=alarm=0, err_count=0, first_ts=0, first_vec=0. Shadow and ts are unaffected.
- The first capture happens only on the ARMED->FAULT/ALARM transition; later mismatches never overwrite first_*.
- Asynchronous reset mid-operation forces the reset values immediately, including shadow and ts.
- All outputs are registered; state is the FSM encoding directly.

Test Plan:
- Reset, arm at cycle 2, drive a=1 enable=1 with target untouched for 50 cycles -> fault=0, err_count=0, state=1.
- Arm, then force target q2 to 1 via VPI for one cycle while s2=0 -> next cycle fault=1, state=2, err_count=1, first_vec=3'b010, first_ts=ts of forced cycle.
- THRESH=4: inject on 4 separate cycles (o3 flipped) -> alarm rises after the 4th; err_count=4; state=3; first_vec stays at first-fault value 3'b100.
- Clear and mismatch in the same cycle while in FAULT -> state=0, err_count=0, fault=0; a further mismatch with no arm causes no change; arm then mismatch -> err_count=1.
- THRESH=1, CNT_W=2: continuous mismatch -> ALARM after the first cycle; err_count saturates at 3 and holds.
- Assert reset asynchronously mid-FAULT between edges -> all outputs 0 immediately; after release, the shadow re-tracks the target and no false mismatch occurs once re-armed.

Source files
------------

// File: rtl/fi_fault_monitor.sv
// fi_fault_monitor
// Golden-model checker that runs beside the fault-injection target.
// It keeps a cycle-accurate shadow of the target's three-flop datapath,
// compares the shadow with the target's registered outputs every cycle and,
// once armed, counts the divergences. It also records when and where the
// first divergence happened, and raises an alarm when the count reaches THRESH.

module fi_fault_monitor #(
    parameter int CNT_W  = 16,
    parameter int TS_W   = 32,
    parameter int THRESH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             arm,
    input  logic             clear,
    input  logic             a,
    input  logic             enable,
    input  logic             o1,
    input  logic             o2,
    input  logic             o3,
    output logic             fault,
    output logic             alarm,
    output logic [CNT_W-1:0] err_count,
    output logic [TS_W-1:0]  first_ts,
    output logic [2:0]       first_vec,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        FAULT = 2'd2,
        ALARM = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] THRESH_V   = CNT_W'(THRESH);
    localparam logic [TS_W-1:0]  TS_MAX     = '1;
    localparam logic [TS_W-1:0]  TS_ONE     = TS_W'(1);
    localparam bit               THRESH_ONE = (THRESH == 1);

    state_t state_q;
    state_t state_d;

    logic s1;
    logic s2;
    logic s3;

    logic [TS_W-1:0] ts;

    logic [2:0]       mis;
    logic             any_mis;
    logic [CNT_W-1:0] cnt_inc;

    logic             fault_d;
    logic             alarm_d;
    logic [CNT_W-1:0] err_count_d;
    logic [TS_W-1:0]  first_ts_d;
    logic [2:0]       first_vec_d;

    // Shadow of the target datapath; it follows the target from reset regardless of FSM state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= enable ? a : s1;
            s2 <= s1;
            s3 <= !s1;
        end
    end

    // Free-running cycle timestamp that sticks at all-ones instead of wrapping
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ts <= '0;
        end else if (ts != TS_MAX) begin
            ts <= ts + TS_ONE;
        end
    end

    // Per-bit divergence between the target outputs and the shadow, plus saturating count increment
    always_comb begin
        mis     = {o3, o2, o1} ^ {s3, s2, s1};
        any_mis = |mis;
        cnt_inc = (err_count == CNT_MAX) ? CNT_MAX : (err_count + CNT_ONE);
    end

    // Next-state and capture logic; clear overrides both arm and any mismatch
    always_comb begin
        state_d     = state_q;
        fault_d     = fault;
        alarm_d     = alarm;
        err_count_d = err_count;
        first_ts_d  = first_ts;
        first_vec_d = first_vec;

        if (clear) begin
            state_d     = IDLE;
            fault_d     = 1'b0;
            alarm_d     = 1'b0;
            err_count_d = '0;
            first_ts_d  = '0;
            first_vec_d = 3'b000;
        end else begin
            case (state_q)
                IDLE: begin
                    if (arm) begin
                        state_d = ARMED;
                    end
                end
                ARMED: begin
                    if (any_mis) begin
                        err_count_d = CNT_ONE;
                        first_ts_d  = ts;
                        first_vec_d = mis;
                        fault_d     = 1'b1;
                        if (THRESH_ONE) begin
                            state_d = ALARM;
                            alarm_d = 1'b1;
                        end else begin
                            state_d = FAULT;
                        end
                    end
                end
                FAULT: begin
                    if (any_mis) begin
                        err_count_d = cnt_inc;
                        if (cnt_inc >= THRESH_V) begin
                            state_d = ALARM;
                            alarm_d = 1'b1;
                        end
                    end
                end
                ALARM: begin
                    if (any_mis) begin
                        err_count_d = cnt_inc;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State register and registered capture outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            fault     <= 1'b0;
            alarm     <= 1'b0;
            err_count <= '0;
            first_ts  <= '0;
            first_vec <= 3'b000;
        end else begin
            state_q   <= state_d;
            fault     <= fault_d;
            alarm     <= alarm_d;
            err_count <= err_count_d;
            first_ts  <= first_ts_d;
            first_vec <= first_vec_d;
        end
    end

    assign state = state_q;

endmodule
